// File: rtl/restador_serie_if.sv
// -----------------------------------------------------------------------------
// restador_serie_if
// Bundles the request/result signals of the serial sign-magnitude subtractor.
//
// Handshake: the master raises start together with valid operands a/b. The
// request is taken on the first rising edge that finds the block idle. busy
// stays high while the operation runs. done is a single-cycle pulse that marks
// res/ovf as valid. res/ovf then hold until the next done.
//
// Signals:
//   start     master -> slave  operation request
//   a, b      master -> slave  minuend / subtrahend, sign-magnitude, N bits
//   busy      slave -> master  high in COMP and CALC
//   done      slave -> master  one-cycle completion pulse
//   res       slave -> master  a - b, sign-magnitude, N bits
//   ovf       slave -> master  magnitude overflow (add path only)
//   dbg_state slave -> master  current FSM state encoding (debug)
// -----------------------------------------------------------------------------
interface restador_serie_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] res;
    logic         ovf;
    logic [1:0]   dbg_state;

    modport master (
        output start, a, b,
        input  busy, done, res, ovf, dbg_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, res, ovf, dbg_state
    );
endinterface

// File: rtl/restador_serie.sv
// -----------------------------------------------------------------------------
// restador_serie
// Serial sign-magnitude subtractor. It computes res = a - b as a + (-b). One
// magnitude bit is processed per clock, LSB first.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    restador_serie_if slave modport (start, a, b, busy, done, res, ovf,
//          dbg_state)
//
// Timing after start is accepted at edge 0:
//   edge 1      : leave COMP (operation type and ordering fixed)
//   edges 2..N  : N-1 CALC cycles, one magnitude bit each
//   edge N      : res/ovf registered and done raised
//   edge N+1    : back to IDLE
// -----------------------------------------------------------------------------
module restador_serie #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    restador_serie_if.slave  bus
);
    localparam int M  = N - 1;                  // magnitude width
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [M-1:0]    r_x;          // minuend magnitude (after ordering)
    logic [M-1:0]    r_y;          // subtrahend/addend magnitude
    logic [M-1:0]    r_acc;        // result bits, shifted in from the MSB side
    logic [CW-1:0]   r_cnt;
    logic            r_carry;      // carry (add) or borrow (subtract)
    logic            r_op_add;
    logic            r_sign_res;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_res;
    logic            r_ovf;

    logic            w_add;
    logic            w_xb;
    logic            w_yb;
    logic            w_sum;
    logic            w_cout;
    logic            w_last;
    logic [M-1:0]    w_acc_next;

    // a - b is a + (-b). Equal effective signs mean the magnitudes are added.
    assign w_add  = (r_sign_a == ~r_sign_b);
    assign w_xb   = r_x[0];
    assign w_yb   = r_y[0];
    assign w_sum  = w_xb ^ w_yb ^ r_carry;
    assign w_last = (r_cnt == CW'(M - 1));

    always_comb begin
        if (r_op_add) begin
            w_cout = (w_xb & w_yb) | (w_xb & r_carry) | (w_yb & r_carry);
        end else begin
            w_cout = (~w_xb & w_yb) | (~w_xb & r_carry) | (w_yb & r_carry);
        end
    end

    // The new bit enters at the top. After M shifts the first (LSB) bit has
    // reached position 0.
    always_comb begin
        w_acc_next        = r_acc >> 1;
        w_acc_next[M-1]   = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_op_add   <= 1'b0;
            r_sign_res <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sign_a <= bus.a[N-1];
                        r_sign_b <= bus.b[N-1];
                        r_x      <= bus.a[M-1:0];
                        r_y      <= bus.b[M-1:0];
                        r_busy   <= 1'b1;
                        r_state  <= COMP;
                    end
                end
                COMP: begin
                    r_op_add <= w_add;
                    r_carry  <= 1'b0;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    if (w_add) begin
                        r_sign_res <= r_sign_a;
                    end else if (r_y > r_x) begin
                        // The larger magnitude becomes the minuend, so no final
                        // borrow can occur. The result takes the sign of -b.
                        r_x        <= r_y;
                        r_y        <= r_x;
                        r_sign_res <= ~r_sign_b;
                    end else begin
                        r_sign_res <= r_sign_a;
                    end
                    r_state <= CALC;
                end
                CALC: begin
                    r_x     <= r_x >> 1;
                    r_y     <= r_y >> 1;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // A zero magnitude is always reported as +0.
                        r_res   <= {(w_acc_next != '0) ? r_sign_res : 1'b0, w_acc_next};
                        r_ovf   <= r_op_add & w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.res       = r_res;
    assign bus.ovf       = r_ovf;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_restador_serie.sv
// -----------------------------------------------------------------------------
// tb_restador_serie
// Self-checking bench for restador_serie. Expected results come from an
// integer-arithmetic model of signed subtraction. They are queued at request
// time and compared by a monitor on every done pulse.
// -----------------------------------------------------------------------------
module tb_restador_serie;
    localparam int N = 4;

    logic clk;
    logic rst_n;

    restador_serie_if #(.N(N)) bus ();

    restador_serie #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fails  = 0;
    logic [N:0]    exp_q[$];     // {ovf, res}
    logic [N:0]    last_exp;
    logic          prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: true signed difference, magnitude wrapped to N-1 bits,
    // overflow when it does not fit, zero always +0.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        int vx, vy, d, m, lim;
        logic [N-1:0] r;
        logic o;
        lim = 1 << (N - 1);
        vx  = int'(x[N-2:0]);
        vy  = int'(y[N-2:0]);
        if (x[N-1]) vx = -vx;
        if (y[N-1]) vy = -vy;
        d = vx - vy;
        m = (d < 0) ? -d : d;
        o = (m >= lim);
        m = m % lim;
        r = N'(m);
        if (d < 0 && m != 0) r[N-1] = 1'b1;
        return {o, r};
    endfunction

    // Monitor: every done pulse must be expected, single-cycle and correct.
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            check("done_width", prev_done, 0);
            check("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("result", {bus.ovf, bus.res}, exp_q.pop_front());
        end
        prev_done = bus.done;
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_b, input logic [N:0] exp);
        int cyc;
        @(negedge clk);
        bus.a     = ta;
        bus.b     = tb_b;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        check("busy_comp", bus.busy, 1);
        check("res_held_on_start", {bus.ovf, bus.res}, last_exp);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 3 * N) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, N);
        check("busy_in_done", bus.busy, 0);
        @(posedge clk); #1;
        check("done_cleared", bus.done, 0);
        check("res_hold", {bus.ovf, bus.res}, exp);
        last_exp = exp;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] ra, rb;
        int cyc;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        last_exp  = '0;
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_res", bus.res, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_state", bus.dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        run_op(4'b0011, 4'b0010, 5'b0_0001);   // +3 - +2
        run_op(4'b0010, 4'b1011, 5'b0_0101);   // +2 - -3
        run_op(4'b1010, 4'b0011, 5'b0_1101);   // -2 - +3
        run_op(4'b1110, 4'b0011, 5'b1_1001);   // -6 - +3, overflow
        run_op(4'b0101, 4'b0101, 5'b0_0000);
        run_op(4'b1000, 4'b0000, 5'b0_0000);   // -0 - +0
        run_op(4'b1011, 4'b1011, 5'b0_0000);
        run_op(4'b0111, 4'b1111, 5'b1_0110);   // 7 + 7 = 14, wraps to 6
        run_op(4'b0001, 4'b0111, 5'b0_1110);   // 1 - 7 = -6

        // Random operands against the model.
        for (int i = 0; i < 150; i++) begin
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = N'($urandom_range(0, (1 << N) - 1));
            run_op(ra, rb, model(ra, rb));
        end

        // Start held high: one done every N+2 cycles. A change of a during
        // CALC must not disturb the running operation.
        for (int k = 0; k < 3; k++) exp_q.push_back(5'b0_0000);
        @(negedge clk);
        bus.a     = 4'b0001;
        bus.b     = 4'b0001;
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 3) bus.a = 4'b0111;
                if (cyc == 4) bus.a = 4'b0001;
                if (bus.done === 1'b1) break;
            end
            if (k == 0) check("b2b_first", cyc, N + 1);
            else        check("b2b_period", cyc, N + 2);
            if (k == 2) bus.start = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle", bus.dbg_state, 0);
        last_exp = '0;

        // Nonzero result first, then an abort during CALC.
        run_op(4'b0110, 4'b1001, 5'b0_0111);
        @(negedge clk);
        bus.a     = 4'b0011;
        bus.b     = 4'b1011;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_res", bus.res, 0);
        check("abort_ovf", bus.ovf, 0);
        check("abort_state", bus.dbg_state, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        check("abort_no_busy", bus.busy, 0);
        check("abort_q_empty", exp_q.size(), 0);
        last_exp = '0;
        run_op(4'b0100, 4'b1010, 5'b0_0110);   // +4 - -2
        run_op(4'b1100, 4'b1001, 5'b0_1011);   // -4 - -1 = -3

        repeat (3) @(posedge clk);
        check("final_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
